pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator: sequences fetch requests, accepts commits, selects
// the next PC among trap/return/jump/branch/sequential targets and raises alignment traps.
module pc_gen #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
   parameter int              IALIGN_BITS = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_pc,
   input  logic            commit_valid,
   output logic            commit_ready,
   input  logic            is_ecall,
   input  logic            is_mret,
   input  logic            jump_flag,
   input  logic            branch_flag,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] branch_pc,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   input  logic            flush_valid,
   input  logic [XLEN-1:0] flush_pc,
   output logic            trap_valid,
   output logic [XLEN-1:0] trap_tval,
   output logic [63:0]     retire_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << IALIGN_BITS) - XLEN'(1);

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] trap_vec;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] cand;
   logic [XLEN-1:0] dnpc;
   logic            misaligned;

   assign fetch_valid  = (state == S_REQ);
   assign commit_ready = (state == S_WAIT);
   assign fetch_pc     = pc;
   assign trap_vec     = {mtvec[XLEN-1:2], 2'b00};
   assign seq_pc       = pc + XLEN'(4);

   // Only jump and branch targets are alignment-checked; a bad one diverts to the trap vector.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      dnpc       = seq_pc;
      cand       = '0;
      misaligned = 1'b0;
      if (is_ecall) begin
         dnpc = trap_vec;
      end else if (is_mret) begin
         dnpc = mepc;
      end else if (jump_flag || branch_flag) begin
         cand       = jump_flag ? {jump_target[XLEN-1:1], 1'b0} : branch_pc;
         misaligned = |(cand & ALIGN_MASK);
         dnpc       = misaligned ? trap_vec : cand;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= S_IDLE;
         pc         <= RESET_PC;
         retire_cnt <= '0;
         trap_valid <= 1'b0;
         trap_tval  <= '0;
      end else begin
         trap_valid <= 1'b0;
         if (flush_valid) begin
            // Flush beats a same-cycle handshake or commit; the IFU drops its in-flight data.
            pc    <= flush_pc;
            state <= S_REQ;
         end else begin
            unique case (state)
               S_IDLE: state <= S_REQ;
               S_REQ:  if (fetch_ready) state <= S_WAIT;
               S_WAIT: begin
                  if (commit_valid) begin
                     pc         <= dnpc;
                     state      <= S_REQ;
                     retire_cnt <= retire_cnt + 64'd1;
                     trap_valid <= misaligned;
                     if (misaligned) trap_tval <= cand;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table plus randomized traffic against a reference model,
// run on two instances (4-byte and 2-byte target alignment) driven in lockstep.
module tb_pc_gen;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, fetch_ready, commit_valid, is_ecall, is_mret, jump_flag, branch_flag, flush_valid;
   logic [31:0] jump_target, branch_pc, mtvec, mepc, flush_pc;

   logic        fv0, cr0, tv0, fv1, cr1, tv1;
   logic [31:0] pc0, tval0, pc1, tval1;
   logic [63:0] cnt0, cnt1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_gen #(.XLEN(32), .RESET_PC(RST_PC), .IALIGN_BITS(2)) u_dut (
      .clk(clk), .rst(rst), .fetch_valid(fv0), .fetch_ready(fetch_ready), .fetch_pc(pc0),
      .commit_valid(commit_valid), .commit_ready(cr0), .is_ecall(is_ecall), .is_mret(is_mret),
      .jump_flag(jump_flag), .branch_flag(branch_flag), .jump_target(jump_target),
      .branch_pc(branch_pc), .mtvec(mtvec), .mepc(mepc), .flush_valid(flush_valid),
      .flush_pc(flush_pc), .trap_valid(tv0), .trap_tval(tval0), .retire_cnt(cnt0));

   pc_gen #(.XLEN(32), .RESET_PC(RST_PC), .IALIGN_BITS(1)) u_dut_c (
      .clk(clk), .rst(rst), .fetch_valid(fv1), .fetch_ready(fetch_ready), .fetch_pc(pc1),
      .commit_valid(commit_valid), .commit_ready(cr1), .is_ecall(is_ecall), .is_mret(is_mret),
      .jump_flag(jump_flag), .branch_flag(branch_flag), .jump_target(jump_target),
      .branch_pc(branch_pc), .mtvec(mtvec), .mepc(mepc), .flush_valid(flush_valid),
      .flush_pc(flush_pc), .trap_valid(tv1), .trap_tval(tval1), .retire_cnt(cnt1));

   typedef struct {
      bit          rst, fr, cv, ecall, mret, jmp, br, fl;
      logic [31:0] jt, bp, mtvec, mepc, fpc;
   } stim_t;

   typedef struct {
      bit          started, waiting, trap;
      logic [31:0] pc, tval;
      logic [63:0] cnt;
   } model_t;

   typedef struct {
      bit [7:0]    ctl;
      logic [31:0] tgt;
      bit          fv, cr, trap;
      logic [31:0] pc0, pc1, tval;
      int          cnt;
   } vec_t;

   localparam bit [7:0] C_RST = 8'h80, C_FR = 8'h40, C_CV = 8'h20, C_EC = 8'h10,
                        C_MR  = 8'h08, C_JMP = 8'h04, C_BR = 8'h02, C_FL = 8'h01;

   // Reference behaviour: one clock edge computed from the architectural rules.
   function automatic model_t model_step(model_t m, stim_t s, int ialign);
      model_t      n = m;
      logic [31:0] t;
      n.trap = 1'b0;
      if (s.rst) begin
         n.started = 0; n.waiting = 0; n.pc = RST_PC; n.cnt = 0; n.tval = 0;
      end else if (s.fl) begin
         n.pc = s.fpc; n.started = 1; n.waiting = 0;
      end else if (!m.started) begin
         n.started = 1;
      end else if (!m.waiting) begin
         if (s.fr) n.waiting = 1;
      end else if (s.cv) begin
         n.waiting = 0;
         n.cnt     = m.cnt + 1;
         if (s.ecall)     n.pc = s.mtvec & ~32'h3;
         else if (s.mret) n.pc = s.mepc;
         else if (s.jmp || s.br) begin
            t = s.jmp ? (s.jt & ~32'h1) : s.bp;
            if (t % (32'd1 << ialign) != 0) begin
               n.pc = s.mtvec & ~32'h3; n.trap = 1; n.tval = t;
            end else begin
               n.pc = t;
            end
         end else n.pc = m.pc + 32'd4;
      end
      return n;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(stim_t s);
      rst = s.rst; fetch_ready = s.fr; commit_valid = s.cv; is_ecall = s.ecall; is_mret = s.mret;
      jump_flag = s.jmp; branch_flag = s.br; flush_valid = s.fl; jump_target = s.jt;
      branch_pc = s.bp; mtvec = s.mtvec; mepc = s.mepc; flush_pc = s.fpc;
   endtask

   function automatic vec_t v(bit [7:0] ctl, logic [31:0] tgt, bit fv, bit cr, bit trap,
                              logic [31:0] p0, logic [31:0] p1, logic [31:0] tval, int cnt);
      vec_t r;
      r.ctl = ctl; r.tgt = tgt; r.fv = fv; r.cr = cr; r.trap = trap;
      r.pc0 = p0; r.pc1 = p1; r.tval = tval; r.cnt = cnt;
      return r;
   endfunction

   vec_t vecs[$];

   initial begin
      stim_t  s;
      model_t m0, m1;

      // Expected values after each edge; pc1 is the 2-byte-aligned instance.
      vecs.push_back(v(C_RST,        0,            0,0,0, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(v(0,            0,            1,0,0, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(v(C_CV,         0,            1,0,0, 32'h8000_0004, 32'h8000_0004, 0, 1));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0004, 32'h8000_0004, 0, 1));
      vecs.push_back(v(C_CV,         0,            1,0,0, 32'h8000_0008, 32'h8000_0008, 0, 2));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0008, 32'h8000_0008, 0, 2));
      vecs.push_back(v(C_CV,         0,            1,0,0, 32'h8000_000c, 32'h8000_000c, 0, 3));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_000c, 32'h8000_000c, 0, 3));
      vecs.push_back(v(C_CV|C_EC|C_JMP, 32'h8000_1003, 1,0,0, 32'h8000_0100, 32'h8000_0100, 0, 4));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0100, 32'h8000_0100, 0, 4));
      vecs.push_back(v(C_CV|C_JMP,   32'h8000_1003, 1,0,1, 32'h8000_0100, 32'h8000_1002, 32'h8000_1002, 5));
      vecs.push_back(v(0,            0,            1,0,0, 32'h8000_0100, 32'h8000_1002, 32'h8000_1002, 5));
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(C_CV|C_JMP, 32'h8000_0040, 1,0,0, 32'h8000_0100, 32'h8000_1002, 32'h8000_1002, 5));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0100, 32'h8000_1002, 32'h8000_1002, 5));
      vecs.push_back(v(C_CV|C_BR|C_FL, 32'h8000_2000, 1,0,0, 32'h8000_2000, 32'h8000_2000, 32'h8000_1002, 5));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_2000, 32'h8000_2000, 32'h8000_1002, 5));
      vecs.push_back(v(C_CV|C_BR,    32'h8000_2001, 1,0,1, 32'h8000_0100, 32'h8000_0100, 32'h8000_2001, 6));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0100, 32'h8000_0100, 32'h8000_2001, 6));
      vecs.push_back(v(C_RST|C_CV|C_JMP, 32'h8000_1003, 0,0,0, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(v(0,            0,            1,0,0, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h8000_0000, 32'h8000_0000, 0, 0));
      vecs.push_back(v(C_FL,         32'hffff_fffc, 1,0,0, 32'hffff_fffc, 32'hffff_fffc, 0, 0));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'hffff_fffc, 32'hffff_fffc, 0, 0));
      vecs.push_back(v(C_CV,         0,            1,0,0, 32'h0000_0000, 32'h0000_0000, 0, 1));
      vecs.push_back(v(C_FR,         0,            0,1,0, 32'h0000_0000, 32'h0000_0000, 0, 1));
      vecs.push_back(v(C_CV|C_MR,    0,            1,0,0, 32'h8000_3000, 32'h8000_3000, 0, 2));
      vecs.push_back(v(C_FR|C_FL,    32'h8000_4000, 1,0,0, 32'h8000_4000, 32'h8000_4000, 0, 2));

      for (int i = 0; i < vecs.size(); i++) begin
         s.rst = vecs[i].ctl[7]; s.fr = vecs[i].ctl[6]; s.cv = vecs[i].ctl[5]; s.ecall = vecs[i].ctl[4];
         s.mret = vecs[i].ctl[3]; s.jmp = vecs[i].ctl[2]; s.br = vecs[i].ctl[1]; s.fl = vecs[i].ctl[0];
         s.jt = vecs[i].tgt; s.bp = vecs[i].tgt; s.fpc = vecs[i].tgt;
         s.mtvec = 32'h8000_0103; s.mepc = 32'h8000_3000;
         drive(s);
         @(posedge clk); #1;
         check($sformatf("v%0d fetch_valid", i),  64'(fv0),   64'(vecs[i].fv));
         check($sformatf("v%0d commit_ready", i), 64'(cr0),   64'(vecs[i].cr));
         check($sformatf("v%0d trap_valid", i),   64'(tv0),   64'(vecs[i].trap));
         check($sformatf("v%0d fetch_pc", i),     64'(pc0),   64'(vecs[i].pc0));
         check($sformatf("v%0d fetch_pc_c", i),   64'(pc1),   64'(vecs[i].pc1));
         check($sformatf("v%0d trap_tval", i),    64'(tval0), 64'(vecs[i].tval));
         check($sformatf("v%0d retire_cnt", i),   cnt0,       64'(vecs[i].cnt));
      end

      // Randomized traffic; the first cycle resets so both models start from a known point.
      m0 = '{default: '0};
      m1 = '{default: '0};
      for (int cyc = 0; cyc < 3000; cyc++) begin
         s.rst   = (cyc == 0) || ($urandom_range(199) == 0);
         s.fl    = ($urandom_range(39) == 0);
         s.fr    = ($urandom_range(9) < 7);
         s.cv    = $urandom_range(1);
         s.ecall = ($urandom_range(7) == 0);
         s.mret  = ($urandom_range(7) == 0);
         s.jmp   = ($urandom_range(3) == 0);
         s.br    = ($urandom_range(3) == 0);
         s.jt    = {16'h8000, 16'($urandom)};
         s.bp    = {16'h8000, 16'($urandom)};
         s.mtvec = {16'h8000, 16'($urandom)};
         s.mepc  = {16'h8000, 16'($urandom)};
         s.fpc   = ($urandom_range(9) == 0) ? 32'hffff_fffc : {16'h8000, 14'($urandom), 2'b00};
         drive(s);
         m0 = model_step(m0, s, 2);
         m1 = model_step(m1, s, 1);
         @(posedge clk); #1;
         check("rnd fetch_valid",  64'(fv0),   64'(m0.started && !m0.waiting));
         check("rnd commit_ready", 64'(cr0),   64'(m0.waiting));
         check("rnd fetch_pc",     64'(pc0),   64'(m0.pc));
         check("rnd trap_valid",   64'(tv0),   64'(m0.trap));
         check("rnd trap_tval",    64'(tval0), 64'(m0.tval));
         check("rnd retire_cnt",   cnt0,       m0.cnt);
         check("rnd_c fetch_valid", 64'(fv1),  64'(m1.started && !m1.waiting));
         check("rnd_c fetch_pc",   64'(pc1),   64'(m1.pc));
         check("rnd_c trap_valid", 64'(tv1),   64'(m1.trap));
         check("rnd_c trap_tval",  64'(tval1), 64'(m1.tval));
         check("rnd_c retire_cnt", cnt1,       m1.cnt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
